// File: rtl/dmem_pkg.sv
// Shared types and constants for the memory-stage access controller.
// Optional build macro: DMEM_MISALIGN_TRAP_EN (enables the misalignment trap helper's use).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  // Halves must sit on an even byte, words on a word boundary; other codes never trap.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_H, F3_HU: return lane[0];
      F3_W:        return lane != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/acknowledge data-memory port between the memory-stage controller and data memory.
// Optional build macro: DMEM_MISALIGN_TRAP_EN (no effect on this interface).
interface dmem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load lane extraction with extension.
// Optional build macro: DMEM_MISALIGN_TRAP_EN (no effect here; lanes always follow the aligned rule).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_funct3)
      F3_B: begin
        st_be    = 4'b0001 << st_lane;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_H: begin
        st_be    = 4'b0011 << {st_lane[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_lane)
      2'd0:    byte_sel = ld_word[7:0];
      2'd1:    byte_sel = ld_word[15:8];
      2'd2:    byte_sel = ld_word[23:16];
      default: byte_sel = ld_word[31:24];
    endcase
    half_sel = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];

    case (ld_funct3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data = {24'b0, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data = {16'b0, half_sel};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage controller: turns E/M load/store controls into a req/ack data-memory transaction and stalls until done.
// Optional build macro: DMEM_MISALIGN_TRAP_EN adds the misaligned output and skips requests for misaligned accesses.
//
// state | meaning
// IDLE  | waiting for a load/store; stalls the pipeline in the detect cycle
// REQ   | request held on the memory port until mem_ack
// DONE  | access finished; pipeline advances on this edge
module dmem_access_ctrl
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  funct3M,
  dmem_access_ctrl_if.master mem,
  output logic        StallMem,
  output logic [31:0] ReadDataM
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  state_t      state, state_nx;
  logic        acc;
  logic        trap;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  // RegWriteM only qualifies the writeback downstream; nothing here depends on it.
  logic unused_regwrite;
  assign unused_regwrite = RegWriteM;

  assign acc = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = acc & is_misaligned(funct3M, ALUResultM[1:0]);
`else
  assign trap = 1'b0;
`endif

  dmem_lane_align u_lane_align (
    .st_funct3 (funct3M),
    .st_lane   (ALUResultM[1:0]),
    .st_data   (WriteDataM),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_funct3 (f3_q),
    .ld_lane   (lane_q),
    .ld_word   (mem.mem_rdata),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc) state_nx = trap ? DONE : REQ;
      REQ:     if (mem.mem_ack) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign StallMem = ((state == IDLE) && acc) || (state == REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'b0;
      mem.mem_wdata <= 32'b0;
      mem.mem_be    <= 4'b0;
      f3_q          <= 3'b0;
      lane_q        <= 2'b0;
      ReadDataM     <= 32'b0;
    end else begin
      state       <= state_nx;
      mem.mem_req <= (state_nx == REQ);
      if ((state == IDLE) && acc && !trap) begin
        mem.mem_we    <= MemWriteM;
        mem.mem_addr  <= {ALUResultM[31:2], 2'b00};
        mem.mem_wdata <= st_wdata;
        mem.mem_be    <= MemWriteM ? st_be : 4'b1111;
        f3_q          <= funct3M;
        lane_q        <= ALUResultM[1:0];
      end
      // Only load completions update the writeback data; stores leave it alone.
      if ((state == REQ) && mem.mem_ack && !mem.mem_we)
        ReadDataM <= ld_data;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misaligned <= 1'b0;
    else       misaligned <= (state == IDLE) && trap;
  end
`endif

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage responder for the control signals registered out of the Execute/Memory pipeline register. It turns RegWriteM/ResultSrcM/MemWriteM plus the ALU address and store data into a request/acknowledge transaction on a variable-latency data-memory port. It stalls the pipeline until the access completes, then returns byte/halfword/word load data, aligned and extended, to the Writeback path. It sits between the E/M register and the M/W register of the pipelined core.

## Interface
- No parameters. Data and address width is fixed at 32 bits.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- RegWriteM  in  1  register write enable; pass-through qualifier only
- ResultSrcM  in  2  result select; 2'b01 marks a load
- MemWriteM  in  1  store request
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, right-aligned
- funct3M  in  3  access size/sign
- mem_req  out  1  request valid toward data memory
- mem_we  out  1  write strobe, valid with mem_req
- mem_addr  out  32  word-aligned address, with {ALUResultM[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  memory completion, single-cycle pulse
- mem_rdata  in  32  read word, valid when mem_ack=1
- StallMem  out  1  freeze of PC, F/D, D/E and E/M registers
- ReadDataM  out  32  extended load result
- misaligned  out  1  only with DMEM_MISALIGN_TRAP_EN

## Operation
- Access condition: acc = MemWriteM | (ResultSrcM==2'b01). MemWriteM has priority if both are set.
- FSM states and transitions:
  - IDLE: if acc, latch addr/wdata/be/we/funct3 and go to REQ; else stay.
  - REQ: mem_req=1. On mem_ack, capture the extracted load data and go to DONE; else stay.
  - DONE: go to IDLE unconditionally.
- StallMem = (state==IDLE & acc) | (state==REQ). It is 0 in DONE, so the pipeline advances on the DONE edge.
- Store byte enables:
  - SB (000): be = 4'b0001<<a[1:0], wdata = {4{wd[7:0]}}.
  - SH (001): be = 4'b0011<<{a[1],1'b0}, wdata = {2{wd[15:0]}}.
  - SW and all other codes: be = 4'b1111.
- Load extraction: select lane by a[1:0].
  - LB (000): sign-extend 8 bits. LBU (100): zero-extend 8 bits.
  - LH (001): sign-extend 16 bits by a[1]. LHU (101): zero-extend 16 bits.
  - LW and codes 011/110/111: full word.
- Loads drive mem_be=4'b1111 and mem_we=0.
- ReadDataM holds its value until the next load's ack. Stores do not modify it.
- mem_req, mem_we, mem_addr, mem_wdata and mem_be are all registered and stable throughout REQ.
- mem_ack outside REQ is ignored.
- reset mid-transaction: state goes to IDLE, mem_req=0 immediately, and the in-flight ack is dropped.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, ReadDataM=0, misaligned=0. StallMem follows its combinational equation.
- Minimum access is 3 cycles: IDLE detect, REQ with ack in the same cycle, DONE. Each ack wait cycle adds one.
- Back-to-back accesses: the next instruction is sampled in IDLE on the cycle after DONE. DONE never re-triggers the same access.
- An ack in the first REQ cycle is legal.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]!=0, issues no request.
  - The FSM goes IDLE→DONE directly.
  - misaligned=1 for exactly the DONE cycle, and ReadDataM is unchanged.
- DMEM_MISALIGN_TRAP_EN undefined:
  - The misaligned port is absent.
  - Half accesses ignore a[0] and word accesses ignore a[1:0]; the access goes to the aligned lane.

## Structure
- Shared package dmem_pkg holds:
  - the state enum (IDLE, REQ, DONE);
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - RESULT_SRC_MEM = 2'b01.
- One sub-module, dmem_lane_align: combinational be/wdata generation and load extraction/extension. The FSM stays in dmem_access_ctrl.

## Test plan
- SW to 0x100, data 0xDEADBEEF, ack after 2 cycles: mem_we=1, be=1111, addr 0x100. StallMem is high for 3 cycles, then low in DONE.
- SB to 0x103, data 0x000000A5: be=1000, wdata=0xA5A5A5A5. ReadDataM is unchanged.
- LB from 0x101, rdata 0x0000_8000, immediate ack: ReadDataM=0xFFFFFF80 in DONE. The LBU variant gives 0x00000080.
- LHU from 0x102, rdata 0xBEEF1234: ReadDataM=0x0000BEEF. The LH variant gives 0xFFFFBEEF.
- Reset asserted during REQ with ack arriving the same cycle: mem_req=0 and state IDLE, ReadDataM=0, and the access does not complete.
- With DMEM_MISALIGN_TRAP_EN, LW at 0x102: mem_req never asserts, and misaligned=1 for one cycle. Without the macro, the same load reads word 0x100.
